// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage RISC-V core.
// Hazard sequencer state encoding and register-index constants.
package riscv_pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: flags an ID source that matches a load in EX.
// x0 is never a hazard since it is hardwired to zero.
module hazard_cmp
  import riscv_pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic             mem_read,
  input  logic [REG_W-1:0] rd,
  output logic             lu
);

  logic hit1;
  logic hit2;

  assign hit1 = uses_rs1 && (rs1 == rd);
  assign hit2 = uses_rs2 && (rs2 == rd);
  assign lu   = mem_read && (rd != REG_X0) && (hit1 || hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, EX redirects, memory freeze.
// HAZARD_PERF_CNT_EN enables the saturating stall/flush counters.
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_enable,
  output logic             if_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_t         state;
  hz_state_t         next_state;
  logic              lu;
  logic              lu_ok;
  logic              lu_act;
  logic              redir_act;
  logic [WAIT_W-1:0] wait_cnt;

  hazard_cmp u_cmp (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .uses_rs1 (id_uses_rs1),
    .uses_rs2 (id_uses_rs2),
    .mem_read (ex_mem_read),
    .rd       (ex_rd),
    .lu       (lu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // ID holds a flushed NOP right after a redirect
  always_comb begin
    lu_ok = 1'b0;
    unique case (state)
      RUN:      lu_ok = lu;
      MEM_WAIT: lu_ok = lu;
      REDIRECT: lu_ok = 1'b0;
      default:  lu_ok = 1'b0;
    endcase
  end

  always_comb begin
    next_state   = RUN;
    pc_write     = 1'b1;
    if_id_enable = 1'b0;
    if_flush     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    lu_act       = 1'b0;
    redir_act    = 1'b0;
    priority case (1'b1)
      reset: begin
        pc_write     = 1'b0;
        if_id_enable = 1'b1;
        if_flush     = 1'b1;
        id_ex_bubble = 1'b1;
      end
      mem_busy: begin
        pc_write     = 1'b0;
        if_id_enable = 1'b1;
        ex_mem_hold  = 1'b1;
        next_state   = MEM_WAIT;
      end
      ex_redirect: begin
        if_id_enable = 1'b1;
        if_flush     = 1'b1;
        id_ex_bubble = 1'b1;
        redir_act    = 1'b1;
        next_state   = REDIRECT;
      end
      lu_ok: begin
        pc_write     = 1'b0;
        if_id_enable = 1'b1;
        id_ex_bubble = 1'b1;
        lu_act       = 1'b1;
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // Counts every consecutive busy cycle, including the one seen in RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      if (!mem_busy) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (mem_busy && (wait_cnt >= WAIT_MAX - WAIT_W'(1))) begin
        mem_timeout_err <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (lu_act && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (redir_act && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  logic cnt_unused;
  assign cnt_unused = ^{lu_act, redir_act};
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed control vectors.
// Control vector order: pc_write, if_id_enable, if_flush, id_ex_bubble, ex_mem_hold.
module tb_hazard_ctrl;

  localparam logic [4:0] NORM  = 5'b10000;
  localparam logic [4:0] STALL = 5'b01010;
  localparam logic [4:0] REDIR = 5'b11110;
  localparam logic [4:0] FRZ   = 5'b01001;
  localparam logic [4:0] RST   = 5'b01110;

`ifdef HAZARD_PERF_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic        mem_busy;
  logic        pc_write;
  logic        if_id_enable;
  logic        if_flush;
  logic        id_ex_bubble;
  logic        ex_mem_hold;
  logic        mem_timeout_err;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [4:0]  ctl;

  int checks;
  int errors;
  int exp_stall;
  int exp_flush;

  assign ctl = {pc_write, if_id_enable, if_flush, id_ex_bubble, ex_mem_hold};

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_redirect     (ex_redirect),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write),
    .if_id_enable    (if_id_enable),
    .if_flush        (if_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_hold     (ex_mem_hold),
    .mem_timeout_err (mem_timeout_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0;
    ex_rd       = 5'd0;
    ex_redirect = 1'b0;
    mem_busy    = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    ex_mem_read = 1'b1;
    ex_rd       = r;
    id_rs1      = r;
    id_uses_rs1 = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_stall = 0;
    exp_flush = 0;
    idle();
    reset = 1'b1;
    #2;
    chk("rst_ctl", 32'(ctl), 32'(RST));
    chk("rst_err", 32'(mem_timeout_err), 0);
    chk("rst_scnt", 32'(stall_cnt), 0);
    chk("rst_fcnt", 32'(flush_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle", 32'(ctl), 32'(NORM));

    // load-use on rs1, one cycle only
    @(negedge clk);
    set_lu(5'd5);
    #1;
    chk("lu_rs1", 32'(ctl), 32'(STALL));
    exp_stall++;
    @(negedge clk);
    idle();
    #1;
    chk("lu_release", 32'(ctl), 32'(NORM));
    chk("stall_cnt1", 32'(stall_cnt), 32'(exp_stall * CNT_ON));

    // rs2 match, then same match with uses_rs2 low
    @(negedge clk);
    ex_mem_read = 1'b1;
    ex_rd       = 5'd7;
    id_rs2      = 5'd7;
    id_uses_rs2 = 1'b1;
    #1;
    chk("lu_rs2", 32'(ctl), 32'(STALL));
    exp_stall++;
    @(negedge clk);
    id_uses_rs2 = 1'b0;
    #1;
    chk("rs2_unused", 32'(ctl), 32'(NORM));

    // x0 filter
    @(negedge clk);
    idle();
    set_lu(5'd0);
    #1;
    chk("x0_filter", 32'(ctl), 32'(NORM));

    // non-load producer
    @(negedge clk);
    set_lu(5'd9);
    ex_mem_read = 1'b0;
    #1;
    chk("no_load", 32'(ctl), 32'(NORM));

    // redirect beats concurrent lu; lu ignored in REDIRECT
    @(negedge clk);
    set_lu(5'd5);
    ex_redirect = 1'b1;
    #1;
    chk("redir_lu", 32'(ctl), 32'(REDIR));
    exp_flush++;
    @(negedge clk);
    ex_redirect = 1'b0;
    #1;
    chk("redir_state", 32'(ctl), 32'(NORM));
    chk("flush_cnt1", 32'(flush_cnt), 32'(exp_flush * CNT_ON));
    cyc();
    chk("lu_after_redir", 32'(ctl), 32'(STALL));
    exp_stall++;
    @(negedge clk);
    idle();
    #1;
    chk("stall_cnt3", 32'(stall_cnt), 32'(exp_stall * CNT_ON));

    // memory wait with redirect held
    @(negedge clk);
    mem_busy    = 1'b1;
    ex_redirect = 1'b1;
    #1;
    chk("frz0", 32'(ctl), 32'(FRZ));
    cyc();
    chk("frz1", 32'(ctl), 32'(FRZ));
    cyc();
    chk("frz2", 32'(ctl), 32'(FRZ));
    @(negedge clk);
    mem_busy = 1'b0;
    #1;
    chk("frz_release", 32'(ctl), 32'(REDIR));
    exp_flush++;
    @(negedge clk);
    ex_redirect = 1'b0;
    #1;
    chk("post_release", 32'(ctl), 32'(NORM));
    chk("flush_cnt2", 32'(flush_cnt), 32'(exp_flush * CNT_ON));

    // busy honoured in REDIRECT
    @(negedge clk);
    ex_redirect = 1'b1;
    #1;
    chk("redir2", 32'(ctl), 32'(REDIR));
    exp_flush++;
    @(negedge clk);
    ex_redirect = 1'b0;
    mem_busy    = 1'b1;
    #1;
    chk("busy_in_redir", 32'(ctl), 32'(FRZ));
    @(negedge clk);
    mem_busy = 1'b0;
    #1;
    chk("busy_in_redir_rel", 32'(ctl), 32'(NORM));
    chk("flush_cnt3", 32'(flush_cnt), 32'(exp_flush * CNT_ON));

    // 15 busy cycles stay below the timeout
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      mem_busy = 1'b1;
    end
    @(negedge clk);
    mem_busy = 1'b0;
    #1;
    chk("to15_err", 32'(mem_timeout_err), 0);
    cyc();
    chk("to15_err_after", 32'(mem_timeout_err), 0);

    // 16 busy cycles reach the timeout
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mem_busy = 1'b1;
      #1;
      if (i == 15) chk("to16_frz", 32'(ctl), 32'(FRZ));
    end
    @(negedge clk);
    #1;
    chk("to16_err", 32'(mem_timeout_err), 1);
    chk("to16_still_frz", 32'(ctl), 32'(FRZ));
    mem_busy = 1'b0;
    #1;
    chk("to16_release", 32'(ctl), 32'(NORM));
    cyc();
    chk("to16_sticky", 32'(mem_timeout_err), 1);

    // async reset in the middle of MEM_WAIT
    @(negedge clk);
    mem_busy    = 1'b1;
    ex_redirect = 1'b1;
    @(posedge clk);
    #3;
    chk("mw_frz", 32'(ctl), 32'(FRZ));
    reset = 1'b1;
    #1;
    chk("mw_rst_ctl", 32'(ctl), 32'(RST));
    chk("mw_rst_err", 32'(mem_timeout_err), 0);
    chk("mw_rst_scnt", 32'(stall_cnt), 0);
    chk("mw_rst_fcnt", 32'(flush_cnt), 0);
    @(negedge clk);
    idle();
    reset = 1'b0;
    #1;
    chk("post_rst", 32'(ctl), 32'(NORM));
    set_lu(5'd3);
    #1;
    chk("post_rst_lu", 32'(ctl), 32'(STALL));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage RISC-V core.
- Drives the IF/ID register's enable and IF_flush inputs, the PC write enable, the ID/EX bubble insert and the EX/MEM hold.
- Detects load-use hazards, applies taken-branch/jump redirects and freezes the pipe while data memory is busy.
- Sits beside the IF/ID and ID/EX registers; all control outputs are consumed in the same cycle.

Parameters:
- MEM_TIMEOUT, 16: max consecutive MEM_WAIT cycles before the sticky error flag sets.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock; state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- mem_busy  in  1  data memory has not completed this cycle.
- pc_write  out  1  1 = PC loads its next value.
- if_id_enable  out  1  drives IF/ID enable; 0 = load, 1 = hold (IF/ID polarity).
- if_flush  out  1  drives IF/ID IF_flush; only effective while if_id_enable = 1.
- id_ex_bubble  out  1  ID/EX captures a NOP instead of the ID instruction.
- ex_mem_hold  out  1  EX/MEM and MEM/WB hold.
- mem_timeout_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  load-use stall cycles (feature gated).
- flush_cnt  out  CNT_W  redirects taken (feature gated).

Behaviour:
- All outputs except the counters and the error flag are combinational from state and inputs, so the cycle a hazard is seen is the cycle it is acted on.
- FSM states: RUN, MEM_WAIT, REDIRECT.
- Reset asserted (async): state = RUN, wait counter = 0, mem_timeout_err = 0, counters = 0. Forced outputs: pc_write = 0, if_id_enable = 1, if_flush = 1, id_ex_bubble = 1, ex_mem_hold = 0.
- Load-use condition (lu): ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)). Register x0 never hazards.
- Priority in RUN: mem_busy > ex_redirect > lu.
- RUN, mem_busy = 1: pc_write = 0, if_id_enable = 1, if_flush = 0, id_ex_bubble = 0, ex_mem_hold = 1; next state MEM_WAIT.
- RUN, ex_redirect = 1: pc_write = 1 (target), if_id_enable = 1, if_flush = 1, id_ex_bubble = 1; next state REDIRECT.
- RUN, lu = 1: pc_write = 0, if_id_enable = 1, if_flush = 0, id_ex_bubble = 1; stay RUN. The stall is exactly 1 cycle because the load moves to MEM.
- RUN, no hazard: pc_write = 1, if_id_enable = 0, all other control outputs 0.
- MEM_WAIT: freeze outputs as in the RUN mem_busy case while mem_busy = 1. The wait counter increments each cycle; on reaching MEM_TIMEOUT, mem_timeout_err sets and the pipe stays frozen. When mem_busy = 0, the wait counter clears and this cycle is evaluated with the RUN rules; next state follows from them. A redirect held in EX during the freeze is therefore applied on release.
- REDIRECT (one cycle): ID holds the flushed NOP, so lu is ignored. mem_busy and ex_redirect are still honoured with the RUN priority; otherwise act as no hazard and return to RUN.
- mem_timeout_err clears only on reset.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt increments on each cycle the lu rule is applied; flush_cnt increments on each redirect. Both saturate at all-ones.
- Undefined: both counters are tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package riscv_pipe_pkg holds the FSM state encoding (RUN = 0, MEM_WAIT = 1, REDIRECT = 2), the REG_X0 = 5'd0 constant and the register-index width of 5.
- One sub-module, hazard_cmp: the combinational load-use comparator producing lu.

Test Plan:
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 -> for exactly 1 cycle pc_write = 0, if_id_enable = 1, id_ex_bubble = 1; stall_cnt = 1.
- x0 filter: ex_rd = 0, id_rs1 = 0, ex_mem_read = 1 -> no stall (pc_write = 1, if_id_enable = 0).
- Redirect: ex_redirect = 1 with a concurrent lu -> if_flush = 1, id_ex_bubble = 1, pc_write = 1; next cycle in REDIRECT, lu ignored; flush_cnt = 1.
- Memory wait: mem_busy high 3 cycles with ex_redirect = 1 held -> 3 frozen cycles (ex_mem_hold = 1), then redirect applied on the release cycle.
- Timeout: mem_busy high for 16 cycles with MEM_TIMEOUT = 16 -> mem_timeout_err = 1, still 1 after mem_busy drops.
- Reset mid-MEM_WAIT: assert reset asynchronously -> state RUN, outputs at reset values immediately, error flag and counters = 0.
